// File: rtl/player_sequencer_if.sv
// player_sequencer_if -- command bus from the CSR block to player_sequencer.
// The master drives a start/stop command with its pass count and gap; the
// slave answers with cmd_ready.
interface player_sequencer_if #(
  parameter int LOOP_BITS = 8,
  parameter int GAP_BITS  = 16
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [LOOP_BITS-1:0] cmd_loops;
  logic [GAP_BITS-1:0]  cmd_gap;

  modport master (output cmd_valid, cmd_op, cmd_loops, cmd_gap, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_loops, cmd_gap, output cmd_ready);
endinterface

// File: rtl/player_sequencer.sv
// player_sequencer -- sequences one sample player: rewinds it, lets it play,
// counts completed passes, inserts an idle gap between passes and stops after
// a programmed number of passes (0 = loop forever).
// Optional feature: define PLAYER_SEQ_TIMEOUT_EN to add a PLAY watchdog that
// raises the sticky fault flag when the player never reports done.
module player_sequencer #(
  parameter int LOOP_BITS    = 8,
  parameter int GAP_BITS     = 16,
  parameter int TIMEOUT_BITS = 12
) (
  input  logic                 r_clk,
  input  logic                 r_reset_n,
  player_sequencer_if.slave    cmd,
  output logic                 p_reset_n,
  input  logic                 p_done,
  output logic                 busy,
  output logic [LOOP_BITS-1:0] loops_done,
  output logic                 pass_pulse,
  output logic                 end_pulse,
  output logic                 aborted,
  output logic                 fault
);

  typedef enum logic [1:0] {IDLE, ARM, PLAY, GAP} state_t;

  localparam logic [LOOP_BITS-1:0] LOOPS_MAX = '1;

  // The watchdog compare happens one cycle early so fault lands exactly when
  // the counter would reach all-ones.
  if (TIMEOUT_BITS < 2) begin : g_timeout_bits_check
    $error("player_sequencer: TIMEOUT_BITS must be at least 2");
  end

  state_t               state;
  logic [LOOP_BITS-1:0] loops_cfg;
  logic [GAP_BITS-1:0]  gap_cfg;
  logic [GAP_BITS-1:0]  gap_cnt;
  logic                 cmd_fire;
  logic                 cmd_start;
  logic                 cmd_stop;
  logic [LOOP_BITS-1:0] loops_next;

`ifdef PLAYER_SEQ_TIMEOUT_EN
  localparam logic [TIMEOUT_BITS-1:0] WD_LIMIT = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};
  logic [TIMEOUT_BITS-1:0] wd_cnt;
`endif

  assign cmd_fire   = cmd.cmd_valid && cmd.cmd_ready;
  assign cmd_start  = cmd_fire && (cmd.cmd_op == 2'b01);
  assign cmd_stop   = cmd_fire && (cmd.cmd_op == 2'b10);
  assign loops_next = (loops_done == LOOPS_MAX) ? loops_done : loops_done + 1'b1;

  // Sequencer FSM: commands take priority over a p_done seen in the same cycle.
  always_ff @(posedge r_clk) begin
    if (!r_reset_n) begin
      state         <= IDLE;
      cmd.cmd_ready <= 1'b0;
      p_reset_n     <= 1'b0;
      busy          <= 1'b0;
      loops_done    <= '0;
      pass_pulse    <= 1'b0;
      end_pulse     <= 1'b0;
      aborted       <= 1'b0;
      loops_cfg     <= '0;
      gap_cfg       <= '0;
      gap_cnt       <= '0;
`ifdef PLAYER_SEQ_TIMEOUT_EN
      fault         <= 1'b0;
      wd_cnt        <= '0;
`endif
    end else begin
      cmd.cmd_ready <= 1'b1;
      pass_pulse    <= 1'b0;
      end_pulse     <= 1'b0;
      if (cmd_start) begin
        loops_cfg  <= cmd.cmd_loops;
        gap_cfg    <= cmd.cmd_gap;
        loops_done <= '0;
        aborted    <= 1'b0;
`ifdef PLAYER_SEQ_TIMEOUT_EN
        fault      <= 1'b0;
`endif
        state      <= ARM;
        busy       <= 1'b1;
        p_reset_n  <= 1'b0;
      end else if (cmd_stop && (state != IDLE)) begin
        state     <= IDLE;
        busy      <= 1'b0;
        p_reset_n <= 1'b0;
        aborted   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            busy      <= 1'b0;
            p_reset_n <= 1'b0;
          end
          ARM: begin
            state     <= PLAY;
            p_reset_n <= 1'b1;
`ifdef PLAYER_SEQ_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
          end
          PLAY: begin
            if (p_done) begin
              pass_pulse <= 1'b1;
              loops_done <= loops_next;
              if ((loops_cfg != '0) && (loops_next == loops_cfg)) begin
                end_pulse <= 1'b1;
                state     <= IDLE;
                busy      <= 1'b0;
                p_reset_n <= 1'b0;
              end else if (gap_cfg == '0) begin
                state     <= ARM;
                p_reset_n <= 1'b0;
              end else begin
                gap_cnt <= gap_cfg;
                state   <= GAP;
              end
            end
`ifdef PLAYER_SEQ_TIMEOUT_EN
            else if (wd_cnt == WD_LIMIT) begin
              fault     <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
              p_reset_n <= 1'b0;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
`endif
          end
          GAP: begin
            if (gap_cnt == GAP_BITS'(1)) begin
              state     <= ARM;
              p_reset_n <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
          default: begin
            state     <= IDLE;
            busy      <= 1'b0;
            p_reset_n <= 1'b0;
          end
        endcase
      end
    end
  end

`ifndef PLAYER_SEQ_TIMEOUT_EN
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_player_sequencer.sv
// tb_player_sequencer -- directed bench for player_sequencer with a 16-entry
// player model (T=4). With PLAYER_SEQ_TIMEOUT_EN defined a second instance
// with TIMEOUT_BITS=3 exercises the watchdog.
module tb_player_sequencer;
  localparam int LOOP_BITS = 8;
  localparam int GAP_BITS  = 16;

  logic                 r_clk = 1'b0;
  logic                 r_reset_n;
  logic                 p_reset_n;
  logic                 p_done;
  logic                 busy;
  logic [LOOP_BITS-1:0] loops_done;
  logic                 pass_pulse;
  logic                 end_pulse;
  logic                 aborted;
  logic                 fault;

  logic [3:0] p_addr;
  logic       force_done_high;
  logic       block_done;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  player_sequencer_if #(.LOOP_BITS(LOOP_BITS), .GAP_BITS(GAP_BITS)) cmd_bus ();

  player_sequencer #(.LOOP_BITS(LOOP_BITS), .GAP_BITS(GAP_BITS), .TIMEOUT_BITS(12)) dut (
    .r_clk      (r_clk),
    .r_reset_n  (r_reset_n),
    .cmd        (cmd_bus),
    .p_reset_n  (p_reset_n),
    .p_done     (p_done),
    .busy       (busy),
    .loops_done (loops_done),
    .pass_pulse (pass_pulse),
    .end_pulse  (end_pulse),
    .aborted    (aborted),
    .fault      (fault)
  );

`ifdef PLAYER_SEQ_TIMEOUT_EN
  logic                 wd_p_reset_n;
  logic                 wd_p_done;
  logic                 wd_busy;
  logic [LOOP_BITS-1:0] wd_loops_done;
  logic                 wd_pass_pulse;
  logic                 wd_end_pulse;
  logic                 wd_aborted;
  logic                 wd_fault;

  player_sequencer_if #(.LOOP_BITS(LOOP_BITS), .GAP_BITS(GAP_BITS)) wd_bus ();

  player_sequencer #(.LOOP_BITS(LOOP_BITS), .GAP_BITS(GAP_BITS), .TIMEOUT_BITS(3)) dut_wd (
    .r_clk      (r_clk),
    .r_reset_n  (r_reset_n),
    .cmd        (wd_bus),
    .p_reset_n  (wd_p_reset_n),
    .p_done     (wd_p_done),
    .busy       (wd_busy),
    .loops_done (wd_loops_done),
    .pass_pulse (wd_pass_pulse),
    .end_pulse  (wd_end_pulse),
    .aborted    (wd_aborted),
    .fault      (wd_fault)
  );
`endif

  // Free-running clock.
  always #5 r_clk = ~r_clk;

  // Cycle counter used to time pulses.
  always @(posedge r_clk) cyc <= cyc + 1;

  // Player model: rewinds while p_reset_n is low, walks to address 15 and holds.
  always @(posedge r_clk) begin
    if (!p_reset_n) p_addr <= 4'd0;
    else if (p_addr != 4'd15) p_addr <= p_addr + 4'd1;
  end

  assign p_done = force_done_high ? 1'b1 : (!block_done && p_reset_n && (p_addr == 4'd15));

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] loops, input logic [15:0] gap);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_loops = loops;
    cmd_bus.cmd_gap   = gap;
    tick();
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = 2'b00;
  endtask

  task automatic wait_pass(input int budget, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (pass_pulse === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    r_reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (cmd_bus.cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_low: got %0b expected 0", cmd_bus.cmd_ready); end
    r_reset_n = 1'b1;
    repeat (5) tick();
    checks++; if (p_reset_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_p_reset_n: got %0b expected 0", p_reset_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if ({pass_pulse, end_pulse} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pulses: got %b expected 00", {pass_pulse, end_pulse}); end
    checks++; if (loops_done !== 8'd0) begin errors++; $display("[TB] FAIL reset_loops_done: got %0d expected 0", loops_done); end
    checks++; if ({aborted, fault} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00", {aborted, fault}); end
    checks++; if (cmd_bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_high: got %0b expected 1", cmd_bus.cmd_ready); end
  endtask

  task automatic test_finite_no_gap();
    int prev, at;
    bit ok;
    send(2'b01, 8'd3, 16'd0);
    prev = cyc;
    checks++; if ({busy, p_reset_n} !== 2'b10) begin errors++; $display("[TB] FAIL fin_arm: got busy,p_reset_n=%b expected 10", {busy, p_reset_n}); end
    tick();
    checks++; if (p_reset_n !== 1'b1) begin errors++; $display("[TB] FAIL fin_play_entry: got %0b expected 1", p_reset_n); end
    for (int k = 1; k <= 3; k++) begin
      wait_pass(40, at, ok);
      checks++; if (!ok || (at - prev) != 17) begin errors++; $display("[TB] FAIL fin_period_%0d: got %0d expected 17", k, at - prev); end
      checks++; if (loops_done !== 8'(k)) begin errors++; $display("[TB] FAIL fin_loops_%0d: got %0d expected %0d", k, loops_done, k); end
      checks++; if (end_pulse !== (k == 3)) begin errors++; $display("[TB] FAIL fin_end_%0d: got %0b expected %0b", k, end_pulse, k == 3); end
      checks++; if (busy !== (k != 3)) begin errors++; $display("[TB] FAIL fin_busy_%0d: got %0b expected %0b", k, busy, k != 3); end
      prev = at;
    end
    tick();
    checks++; if ({pass_pulse, end_pulse, p_reset_n} !== 3'b000) begin errors++; $display("[TB] FAIL fin_after: got %b expected 000", {pass_pulse, end_pulse, p_reset_n}); end
  endtask

  task automatic test_gap();
    int prev, at, n;
    bit ok;
    send(2'b01, 8'd2, 16'd5);
    prev = cyc;
    wait_pass(40, at, ok);
    checks++; if (!ok || (at - prev) != 17) begin errors++; $display("[TB] FAIL gap_first: got %0d expected 17", at - prev); end
    prev = at;
    n = 0;
    while (p_reset_n === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    checks++; if (n != 5) begin errors++; $display("[TB] FAIL gap_high_cycles: got %0d expected 5", n); end
    wait_pass(40, at, ok);
    checks++; if (!ok || (at - prev) != 22) begin errors++; $display("[TB] FAIL gap_period: got %0d expected 22", at - prev); end
    checks++; if ({end_pulse, busy, loops_done} !== {2'b10, 8'd2}) begin errors++; $display("[TB] FAIL gap_end: got end=%0b busy=%0b loops=%0d expected 1 0 2", end_pulse, busy, loops_done); end
  endtask

  task automatic test_stop_infinite();
    int prev, at;
    bit ok;
    send(2'b01, 8'd0, 16'd0);
    prev = cyc;
    for (int k = 1; k <= 4; k++) begin
      wait_pass(40, at, ok);
      checks++; if (!ok || (at - prev) != 17 || end_pulse !== 1'b0) begin errors++; $display("[TB] FAIL inf_pass_%0d: got period %0d end %0b expected 17 0", k, at - prev, end_pulse); end
      prev = at;
    end
    repeat (5) tick();
    checks++; if (p_reset_n !== 1'b1) begin errors++; $display("[TB] FAIL inf_playing: got %0b expected 1", p_reset_n); end
    send(2'b10, 8'd0, 16'd0);
    checks++; if ({p_reset_n, busy, aborted} !== 3'b001) begin errors++; $display("[TB] FAIL stop_flags: got p_reset_n,busy,aborted=%b expected 001", {p_reset_n, busy, aborted}); end
    checks++; if (loops_done !== 8'd4) begin errors++; $display("[TB] FAIL stop_loops: got %0d expected 4", loops_done); end
    checks++; if ({pass_pulse, end_pulse} !== 2'b00) begin errors++; $display("[TB] FAIL stop_pulses: got %b expected 00", {pass_pulse, end_pulse}); end
    send(2'b10, 8'd0, 16'd0);
    checks++; if ({busy, aborted, loops_done} !== {2'b01, 8'd4}) begin errors++; $display("[TB] FAIL stop_idle: got busy=%0b aborted=%0b loops=%0d expected 0 1 4", busy, aborted, loops_done); end
  endtask

  task automatic test_stop_on_done();
    bit found;
    send(2'b01, 8'd5, 16'd0);
    checks++; if (aborted !== 1'b0) begin errors++; $display("[TB] FAIL sod_abort_clear: got %0b expected 0", aborted); end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (p_done === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL sod_done_seen: got 0 expected 1"); end
    send(2'b10, 8'd0, 16'd0);
    checks++; if ({pass_pulse, busy, aborted} !== 3'b001) begin errors++; $display("[TB] FAIL sod_flags: got pass,busy,aborted=%b expected 001", {pass_pulse, busy, aborted}); end
    checks++; if (loops_done !== 8'd0) begin errors++; $display("[TB] FAIL sod_loops: got %0d expected 0", loops_done); end
    tick();
    checks++; if (pass_pulse !== 1'b0) begin errors++; $display("[TB] FAIL sod_late_pass: got %0b expected 0", pass_pulse); end
  endtask

  task automatic test_restart();
    int at, acc;
    bit ok;
    send(2'b01, 8'd0, 16'd0);
    wait_pass(40, at, ok);
    checks++; if (!ok || loops_done !== 8'd1) begin errors++; $display("[TB] FAIL rs_first: got loops %0d expected 1", loops_done); end
    repeat (3) tick();
    send(2'b01, 8'd1, 16'd2);
    acc = cyc;
    checks++; if ({loops_done, p_reset_n, busy, aborted} !== {8'd0, 3'b010}) begin errors++; $display("[TB] FAIL rs_relatch: got loops=%0d p_reset_n=%0b busy=%0b aborted=%0b expected 0 0 1 0", loops_done, p_reset_n, busy, aborted); end
    wait_pass(40, at, ok);
    checks++; if (!ok || (at - acc) != 17) begin errors++; $display("[TB] FAIL rs_period: got %0d expected 17", at - acc); end
    checks++; if ({end_pulse, busy, loops_done} !== {2'b10, 8'd1}) begin errors++; $display("[TB] FAIL rs_end: got end=%0b busy=%0b loops=%0d expected 1 0 1", end_pulse, busy, loops_done); end
  endtask

  task automatic test_saturation();
    int at;
    bit ok;
    force_done_high = 1'b1;
    send(2'b01, 8'd0, 16'd0);
    repeat (600) tick();
    checks++; if ({busy, loops_done} !== {1'b1, 8'd255}) begin errors++; $display("[TB] FAIL sat_value: got busy=%0b loops=%0d expected 1 255", busy, loops_done); end
    wait_pass(4, at, ok);
    checks++; if (!ok || loops_done !== 8'd255) begin errors++; $display("[TB] FAIL sat_continue: got pass=%0b loops=%0d expected 1 255", ok, loops_done); end
    send(2'b10, 8'd0, 16'd0);
    force_done_high = 1'b0;
    checks++; if ({busy, aborted, loops_done} !== {2'b01, 8'd255}) begin errors++; $display("[TB] FAIL sat_stop: got busy=%0b aborted=%0b loops=%0d expected 0 1 255", busy, aborted, loops_done); end
  endtask

`ifdef PLAYER_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    wd_bus.cmd_valid = 1'b1;
    wd_bus.cmd_op    = 2'b01;
    wd_bus.cmd_loops = 8'd1;
    wd_bus.cmd_gap   = 16'd0;
    tick();
    wd_bus.cmd_valid = 1'b0;
    tick();
    repeat (6) tick();
    checks++; if ({wd_fault, wd_busy} !== 2'b01) begin errors++; $display("[TB] FAIL wd_before: got fault,busy=%b expected 01", {wd_fault, wd_busy}); end
    tick();
    checks++; if ({wd_fault, wd_busy, wd_p_reset_n, wd_end_pulse} !== 4'b1000) begin errors++; $display("[TB] FAIL wd_fire: got fault,busy,p_reset_n,end=%b expected 1000", {wd_fault, wd_busy, wd_p_reset_n, wd_end_pulse}); end
    wd_bus.cmd_valid = 1'b1;
    tick();
    wd_bus.cmd_valid = 1'b0;
    checks++; if ({wd_fault, wd_busy} !== 2'b01) begin errors++; $display("[TB] FAIL wd_clear: got fault,busy=%b expected 01", {wd_fault, wd_busy}); end
    wd_bus.cmd_valid = 1'b1;
    wd_bus.cmd_op    = 2'b10;
    tick();
    wd_bus.cmd_valid = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    block_done = 1'b1;
    send(2'b01, 8'd1, 16'd0);
    repeat (40) tick();
    checks++; if ({fault, busy, p_reset_n} !== 3'b011) begin errors++; $display("[TB] FAIL nowd_wait: got fault,busy,p_reset_n=%b expected 011", {fault, busy, p_reset_n}); end
    send(2'b10, 8'd0, 16'd0);
    block_done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nowd_stop: got %0b expected 0", busy); end
  endtask
`endif

  task automatic test_reset_midrun();
    int at;
    bit ok;
    send(2'b01, 8'd0, 16'd3);
    wait_pass(40, at, ok);
    repeat (3) tick();
    r_reset_n = 1'b0;
    tick();
    checks++; if ({ok, p_reset_n, busy, pass_pulse, end_pulse, aborted, fault} !== 7'b1000000) begin errors++; $display("[TB] FAIL mid_reset_flags: got %b expected 1000000", {ok, p_reset_n, busy, pass_pulse, end_pulse, aborted, fault}); end
    checks++; if ({cmd_bus.cmd_ready, loops_done} !== {1'b0, 8'd0}) begin errors++; $display("[TB] FAIL mid_reset_state: got ready=%0b loops=%0d expected 0 0", cmd_bus.cmd_ready, loops_done); end
    r_reset_n = 1'b1;
    tick();
    checks++; if ({cmd_bus.cmd_ready, busy} !== 2'b10) begin errors++; $display("[TB] FAIL mid_reset_release: got ready,busy=%b expected 10", {cmd_bus.cmd_ready, busy}); end
  endtask

  // Directed test sequence.
  initial begin
    r_reset_n         = 1'b0;
    force_done_high   = 1'b0;
    block_done        = 1'b0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = 2'b00;
    cmd_bus.cmd_loops = '0;
    cmd_bus.cmd_gap   = '0;
`ifdef PLAYER_SEQ_TIMEOUT_EN
    wd_p_done        = 1'b0;
    wd_bus.cmd_valid = 1'b0;
    wd_bus.cmd_op    = 2'b00;
    wd_bus.cmd_loops = '0;
    wd_bus.cmd_gap   = '0;
`endif
    test_reset();
    test_finite_no_gap();
    test_gap();
    test_stop_infinite();
    test_stop_on_done();
    test_restart();
    test_saturation();
`ifdef PLAYER_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
